// File: rtl/alu_digit_seq_pkg.sv
// Shared types and helpers for the digit-serial integer execution unit.
package alu_digit_seq_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        XOR  = 3'd2,
        OR   = 3'd3,
        AND  = 3'd4,
        SLT  = 3'd5,
        SLTU = 3'd6,
        EQ   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Subtract and both compares run A + ~B + 1 through the carry chain.
    function automatic logic needs_inv(op_e op);
        return (op == SUB) || (op == SLT) || (op == SLTU);
    endfunction

endpackage

// File: rtl/alu_digit_seq_if.sv
// Request/response handshake bundle between operand fetch and writeback.
interface alu_digit_seq_if #(
    parameter int XLEN = 32
);
    import alu_digit_seq_pkg::*;

    logic            req_valid;
    logic            req_ready;
    op_e             req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, kill, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, kill, resp_ready,
        output req_ready, resp_valid, resp_result
    );

endinterface

// File: rtl/alu_digit_seq_slice.sv
// Combinational W-bit digit: add/logic result plus chained equality and less-than.
module alu_digit_slice
    import alu_digit_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_d,
    input  logic [W-1:0] b_d,
    input  logic         cin,
    input  op_e          op,
    input  logic         eq_in,
    input  logic         lt_in,
    input  logic         is_msb,
    input  logic         signed_cmp,
    output logic [W-1:0] r_d,
    output logic         cout,
    output logic         eq_out,
    output logic         lt_out
);
    logic [W-1:0]        w_b_eff;
    logic [W:0]          w_sum;
    logic signed [W-1:0] w_a_s;
    logic signed [W-1:0] w_b_s;
    logic                w_eq_d;
    logic                w_lt_d;

    assign w_a_s = a_d;
    assign w_b_s = b_d;

    always_comb begin
        w_b_eff = needs_inv(op) ? ~b_d : b_d;
        w_sum   = {1'b0, a_d} + {1'b0, w_b_eff} + {{W{1'b0}}, cin};
        w_eq_d  = (a_d == b_d);
        // Only the most significant digit of a signed compare carries the sign.
        if (is_msb && signed_cmp) begin
            w_lt_d = (w_a_s < w_b_s);
        end else begin
            w_lt_d = (a_d < b_d);
        end

        case (op)
            ADD, SUB, SLT, SLTU: r_d = w_sum[W-1:0];
            XOR:                 r_d = a_d ^ b_d;
            OR:                  r_d = a_d | b_d;
            AND:                 r_d = a_d & b_d;
            default:             r_d = '0;
        endcase

        cout   = w_sum[W];
        eq_out = eq_in & w_eq_d;
        lt_out = w_lt_d | (w_eq_d & lt_in);
    end

endmodule

// File: rtl/alu_digit_seq.sv
// Digit-serial ALU/compare unit: LSB-first, DIGIT_W bits per cycle, full-width handshakes.
module alu_digit_seq
    import alu_digit_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_digit_seq_if.slave bus
);
    localparam int NDIG = XLEN / DIGIT_W;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((XLEN % DIGIT_W) != 0) begin : g_bad_digit
        $error("XLEN must be a multiple of DIGIT_W");
    end

    state_e               r_state;
    state_e               w_state_nxt;
    op_e                  r_op;
    logic [CW-1:0]        r_cnt;
    logic                 r_carry;
    logic                 r_eq;
    logic                 r_lt;
    logic                 r_vld;
    logic [XLEN-1:0]      r_out;
    logic [XLEN-1:0]      r_a;
    logic [XLEN-1:0]      r_b;
    logic [XLEN-1:0]      r_res;

    logic                 w_accept;
    logic                 w_last;
    logic [DIGIT_W-1:0]   w_rd;
    logic                 w_cout;
    logic                 w_eq;
    logic                 w_lt;
    logic [XLEN-1:0]      w_a_shift;
    logic [XLEN-1:0]      w_b_shift;
    logic [XLEN-1:0]      w_res_shift;

    function automatic logic [XLEN-1:0] final_result(op_e op, logic [XLEN-1:0] res,
                                                     logic lt, logic eq);
        case (op)
            ADD, SUB, XOR, OR, AND: final_result = res;
            SLT, SLTU:              final_result = {{(XLEN-1){1'b0}}, lt};
            EQ:                     final_result = {{(XLEN-1){1'b0}}, eq};
            default:                final_result = '0;
        endcase
    endfunction

    assign bus.req_ready   = (r_state == IDLE) && !bus.kill;
    assign bus.resp_valid  = r_vld;
    assign bus.resp_result = r_out;

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(NDIG - 1));

    alu_digit_slice #(.W(DIGIT_W)) u_slice (
        .a_d        (r_a[DIGIT_W-1:0]),
        .b_d        (r_b[DIGIT_W-1:0]),
        .cin        (r_carry),
        .op         (r_op),
        .eq_in      (r_eq),
        .lt_in      (r_lt),
        .is_msb     (w_last),
        .signed_cmp (r_op == SLT),
        .r_d        (w_rd),
        .cout       (w_cout),
        .eq_out     (w_eq),
        .lt_out     (w_lt)
    );

    if (NDIG == 1) begin : g_single
        assign w_a_shift   = '0;
        assign w_b_shift   = '0;
        assign w_res_shift = w_rd;
    end else begin : g_multi
        assign w_a_shift   = {{DIGIT_W{1'b0}}, r_a[XLEN-1:DIGIT_W]};
        assign w_b_shift   = {{DIGIT_W{1'b0}}, r_b[XLEN-1:DIGIT_W]};
        assign w_res_shift = {w_rd, r_res[XLEN-1:DIGIT_W]};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN: begin
                if (bus.kill)    w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.kill)                      w_state_nxt = IDLE;
                else if (r_vld && bus.resp_ready)  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= ADD;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_vld   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op    <= bus.req_op;
                    r_cnt   <= '0;
                    r_carry <= needs_inv(bus.req_op);
                    r_eq    <= 1'b1;
                    r_lt    <= 1'b0;
                end
                RUN: begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_carry <= w_cout;
                    r_eq    <= w_eq;
                    r_lt    <= w_lt;
                end
                // First DONE cycle registers the response; it then holds until taken.
                DONE: begin
                    if (bus.kill) begin
                        r_vld <= 1'b0;
                    end else if (!r_vld) begin
                        r_vld <= 1'b1;
                        r_out <= final_result(r_op, r_res, r_lt, r_eq);
                    end else if (bus.resp_ready) begin
                        r_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.req_rs1;
            r_b <= bus.req_rs2;
        end else if (r_state == RUN) begin
            r_a   <= w_a_shift;
            r_b   <= w_b_shift;
            r_res <= w_res_shift;
        end
    end

endmodule

// File: tb/tb_alu_digit_seq.sv
// Bench for alu_digit_seq: directed vectors, corner sequences and a DIGIT_W sweep vs a reference model.
module tb_alu_digit_seq;
    import alu_digit_seq_pkg::*;

    localparam int XLEN = 32;
    localparam int NDIG0 = XLEN / 4;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic rst0;

    alu_digit_seq_if #(.XLEN(XLEN)) if0 ();
    alu_digit_seq #(.XLEN(XLEN), .DIGIT_W(4)) dut0 (.clk(clk), .rst_n(rst0), .bus(if0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(op_e op, logic [31:0] a, logic [31:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            XOR:     return a ^ b;
            OR:      return a | b;
            AND:     return a & b;
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:    return (a < b) ? 32'd1 : 32'd0;
            EQ:      return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'h8000_0000 | 32'($urandom_range(0, 15));
            2:       return 32'($urandom_range(0, 15));
            default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic op_e rand_op();
        logic [2:0] r3;
        r3 = 3'($urandom_range(0, 7));
        return op_e'(r3);
    endfunction

    task automatic issue0(input op_e op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        if0.req_op = op; if0.req_rs1 = a; if0.req_rs2 = b; if0.req_valid = 1'b1;
        #1;
        while (!if0.req_ready && n < 50) begin tick(); n++; end
        chk1("req_accept", if0.req_ready, 1'b1);
        tick();
        if0.req_valid = 1'b0;
    endtask

    task automatic wait0(output logic [31:0] res, output int lat);
        lat = 0;
        while (!if0.resp_valid && lat < 200) begin tick(); lat++; end
        chk1("resp_seen", if0.resp_valid, 1'b1);
        res = if0.resp_result;
    endtask

    task automatic run0(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
        issue0(op, a, b);
        wait0(res, lat);
        tick();
    endtask

    // DIGIT_W sweep: one DUT per width, each driven by its own random process.
    for (genvar k = 0; k < 4; k++) begin : g_sw
        localparam int DW = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 32;
        localparam int ND = XLEN / DW;
        logic rst_g;
        bit   done;
        alu_digit_seq_if #(.XLEN(XLEN)) ifs ();
        alu_digit_seq #(.XLEN(XLEN), .DIGIT_W(DW)) dut (.clk(clk), .rst_n(rst_g), .bus(ifs));

        initial begin
            int lat, n;
            logic [31:0] a, b, expv;
            op_e op;
            done = 1'b0;
            rst_g = 1'b0;
            ifs.req_valid = 1'b0; ifs.kill = 1'b0; ifs.resp_ready = 1'b1;
            ifs.req_op = ADD; ifs.req_rs1 = '0; ifs.req_rs2 = '0;
            repeat (3) tick();
            rst_g = 1'b1;
            tick();
            for (int i = 0; i < 24; i++) begin
                op = rand_op();
                a = pick();
                b = ($urandom_range(0, 3) == 0) ? a : pick();
                expv = ref_alu(op, a, b);
                n = 0;
                ifs.req_op = op; ifs.req_rs1 = a; ifs.req_rs2 = b; ifs.req_valid = 1'b1;
                #1;
                while (!ifs.req_ready && n < 50) begin tick(); n++; end
                chk1($sformatf("dw%0d_accept", DW), ifs.req_ready, 1'b1);
                tick();
                ifs.req_valid = 1'b0;
                if (i == 12) begin
                    rst_g = 1'b0;
                    #1;
                    chk1($sformatf("dw%0d_rst_req_ready", DW), ifs.req_ready, 1'b1);
                    chk1($sformatf("dw%0d_rst_resp_valid", DW), ifs.resp_valid, 1'b0);
                    chk($sformatf("dw%0d_rst_resp_result", DW), ifs.resp_result, 32'd0);
                    tick();
                    rst_g = 1'b1;
                    n = 0;
                    repeat (ND + 4) begin tick(); if (ifs.resp_valid) n++; end
                    chk($sformatf("dw%0d_no_stale", DW), n, 0);
                end else begin
                    lat = 0;
                    while (!ifs.resp_valid && lat < ND + 10) begin tick(); lat++; end
                    chk($sformatf("dw%0d_op%0d_result", DW, op), ifs.resp_result, expv);
                    chk($sformatf("dw%0d_latency", DW), lat, ND + 1);
                    tick();
                end
            end
            done = 1'b1;
        end
    end

    initial begin
        vec_t vecs[13];
        logic [31:0] res, cap;
        int lat, n;

        rst0 = 1'b0;
        if0.req_valid = 1'b0; if0.kill = 1'b0; if0.resp_ready = 1'b1;
        if0.req_op = ADD; if0.req_rs1 = '0; if0.req_rs2 = '0;
        repeat (2) tick();
        chk1("reset_req_ready", if0.req_ready, 1'b1);
        chk1("reset_resp_valid", if0.resp_valid, 1'b0);
        chk("reset_resp_result", if0.resp_result, 32'd0);
        rst0 = 1'b1;
        tick();

        vecs[0]  = '{ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{SUB,  32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2]  = '{XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[3]  = '{SLT,  32'h8000_0000, 32'h0000_0001, 32'd1};
        vecs[4]  = '{SLTU, 32'h8000_0000, 32'h0000_0001, 32'd0};
        vecs[5]  = '{EQ,   32'h1234_5678, 32'h1234_5678, 32'd1};
        vecs[6]  = '{EQ,   32'h1234_5678, 32'h1234_5679, 32'd0};
        vecs[7]  = '{OR,   32'h00FF_0000, 32'h0000_FF01, 32'h00FF_FF01};
        vecs[8]  = '{AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[9]  = '{SLT,  32'h0000_0001, 32'h8000_0000, 32'd0};
        vecs[10] = '{SLT,  32'hFFFF_FFFF, 32'h0000_0000, 32'd1};
        vecs[11] = '{SLTU, 32'hFFFF_FFFF, 32'h0000_0000, 32'd0};
        vecs[12] = '{SUB,  32'd0,         32'd1,         32'hFFFF_FFFF};

        for (int i = 0; i < 13; i++) begin
            run0(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, NDIG0 + 1);
        end

        for (int i = 0; i < 30; i++) begin
            op_e op;
            logic [31:0] a, b;
            op = rand_op();
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            run0(op, a, b, res, lat);
            chk($sformatf("rand%0d_op%0d", i, op), res, ref_alu(op, a, b));
        end

        // Unbounded stall on the response side.
        if0.resp_ready = 1'b0;
        issue0(ADD, 32'h0000_1234, 32'h0000_1111);
        wait0(cap, lat);
        chk("stall_first_result", cap, 32'h0000_2345);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("stall_valid", if0.resp_valid, 1'b1);
            chk("stall_result", if0.resp_result, cap);
            chk1("stall_req_ready", if0.req_ready, 1'b0);
        end
        if0.resp_ready = 1'b1;
        tick();
        chk1("release_resp_valid", if0.resp_valid, 1'b0);
        chk1("release_req_ready", if0.req_ready, 1'b1);
        run0(SUB, 32'd10, 32'd3, res, lat);
        chk("after_stall_result", res, 32'd7);

        // Abort on the third RUN cycle.
        issue0(ADD, 32'hDEAD_BEEF, 32'h0101_0101);
        tick();
        tick();
        if0.kill = 1'b1;
        tick();
        if0.kill = 1'b0;
        #1;
        chk1("kill_req_ready", if0.req_ready, 1'b1);
        chk1("kill_resp_valid", if0.resp_valid, 1'b0);
        n = 0;
        repeat (NDIG0 + 4) begin tick(); if (if0.resp_valid) n++; end
        chk("kill_no_resp", n, 0);
        run0(ADD, 32'd2, 32'd3, res, lat);
        chk("after_kill_result", res, 32'd5);

        // A request offered alongside kill in IDLE must not be taken.
        if0.req_op = ADD; if0.req_rs1 = 32'd1; if0.req_rs2 = 32'd1;
        if0.kill = 1'b1; if0.req_valid = 1'b1;
        #1;
        chk1("kill_idle_ready", if0.req_ready, 1'b0);
        tick();
        if0.kill = 1'b0; if0.req_valid = 1'b0;
        #1;
        chk1("kill_idle_still_idle", if0.req_ready, 1'b1);
        n = 0;
        repeat (NDIG0 + 4) begin tick(); if (if0.resp_valid) n++; end
        chk("kill_idle_no_resp", n, 0);

        // Asynchronous reset in the middle of RUN.
        issue0(XOR, 32'hAAAA_5555, 32'h1234_4321);
        tick();
        rst0 = 1'b0;
        #1;
        chk1("midrst_req_ready", if0.req_ready, 1'b1);
        chk1("midrst_resp_valid", if0.resp_valid, 1'b0);
        chk("midrst_resp_result", if0.resp_result, 32'd0);
        tick();
        rst0 = 1'b1;
        n = 0;
        repeat (NDIG0 + 4) begin tick(); if (if0.resp_valid) n++; end
        chk("midrst_no_stale", n, 0);
        run0(ADD, 32'd7, 32'd8, res, lat);
        chk("after_midrst_result", res, 32'd15);

        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 20000) begin
            tick();
            n++;
        end
        chk1("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
